// File: rtl/lift_sched.sv
// lift_sched: single-car SCAN scheduler for a four-floor lift.
// Tracks pending floor calls, commands the car toward the next floor in the
// current travel direction and holds the door open for DOOR_CYC cycles per stop.
// Optional build macro: LIFT_SCHED_HOLD_EN -- a call for the current floor while
// the door is open restarts the door timer instead of being dropped.
module lift_sched #(
  parameter int unsigned DOOR_CYC = 4
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic [3:0] in_call,
  input  logic [2:0] in_pos,
  input  logic       in_rdy,
  output logic [1:0] o_tgt,
  output logic [3:0] o_pend,
  output logic       o_dir,
  output logic       o_door,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  localparam logic [3:0] DOOR_LD = 4'(DOOR_CYC);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] tgt_nxt;
  logic       dir_nxt;
  logic [3:0] pend_nxt;
  logic [3:0] clr;
  logic [3:0] req;
  logic [3:0] door_clr;
  logic [3:0] door_pend;
  logic       pos_ok;
  logic [1:0] cur;
  logic [3:0] sc;
  logic [2:0] mv;

  // Nearest set bit of mask moving away from 'from' in one direction.
  // Returns {found, index}; incl allows 'from' itself to match.
  function automatic logic [2:0] seek(input logic [3:0] mask, input logic [1:0] from,
                                      input logic up, input logic incl);
    logic [2:0] res;
    logic [1:0] i;
    logic       ok;
    res = {1'b0, from};
    for (int unsigned k = 0; k < 4; k++) begin
      i  = up ? k[1:0] : 2'(3 - k);
      ok = up ? (incl ? (i >= from) : (i > from))
              : (incl ? (i <= from) : (i < from));
      if (!res[2] && ok && mask[i]) res = {1'b1, i};
    end
    return res;
  endfunction

  // SCAN pick with reversal: returns {found, new_dir, target}.
  function automatic logic [3:0] scan(input logic [3:0] mask, input logic [1:0] from,
                                      input logic dir, input logic [1:0] keep);
    logic [2:0] a;
    logic [2:0] b;
    a = seek(mask, from, dir, 1'b0);
    b = seek(mask, from, ~dir, 1'b0);
    if (a[2])      return {1'b1, dir, a[1:0]};
    else if (b[2]) return {1'b1, ~dir, b[1:0]};
    else           return {1'b0, dir, keep};
  endfunction

  assign pos_ok    = (in_pos >= 3'd1) && (in_pos <= 3'd4);
  assign cur       = 2'(in_pos - 3'd1);
  assign req       = o_pend | in_call;
  assign door_clr  = pos_ok ? (4'b0001 << cur) : 4'b0000;
  assign door_pend = req & ~door_clr;

  assign o_door = (state == DOOR);
  assign o_busy = (state != IDLE);

  // State, target, direction, pending mask and door timer registers.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state  <= IDLE;
      o_tgt  <= '0;
      o_pend <= '0;
      o_dir  <= 1'b1;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      o_tgt  <= tgt_nxt;
      o_pend <= pend_nxt;
      o_dir  <= dir_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Next-state, target selection, floor clear and door timer.
  always_comb begin
    state_nxt = state;
    tgt_nxt   = o_tgt;
    dir_nxt   = o_dir;
    cnt_nxt   = cnt;
    clr       = '0;
    sc        = '0;
    mv        = '0;
    case (state)
      IDLE: begin
        if (req != 4'b0000) begin
          if (pos_ok && req[cur]) begin
            clr[cur]  = 1'b1;
            cnt_nxt   = DOOR_LD;
            state_nxt = DOOR;
          end else begin
            sc = scan(req, cur, o_dir, o_tgt);
            if (sc[3]) begin
              dir_nxt   = sc[2];
              tgt_nxt   = sc[1:0];
              state_nxt = MOVE;
            end
          end
        end
      end
      MOVE: begin
        if (pos_ok && in_rdy && (cur == o_tgt)) begin
          clr[o_tgt] = 1'b1;
          cnt_nxt    = DOOR_LD;
          state_nxt  = DOOR;
        end else if (pos_ok) begin
          // Same-direction search includes cur so a target already reached
          // but not yet confirmed by in_rdy is not skipped.
          mv = seek(req, cur, o_dir, 1'b1);
          if (mv[2]) tgt_nxt = mv[1:0];
        end
      end
      DOOR: begin
        clr = door_clr;
`ifdef LIFT_SCHED_HOLD_EN
        if (pos_ok && in_call[cur]) begin
          cnt_nxt = DOOR_LD;
        end else
`endif
        if (cnt <= 4'd1) begin
          cnt_nxt = '0;
          if (door_pend == 4'b0000) begin
            state_nxt = IDLE;
          end else begin
            sc        = scan(door_pend, cur, o_dir, o_tgt);
            dir_nxt   = sc[2];
            tgt_nxt   = sc[1:0];
            state_nxt = MOVE;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    pend_nxt = req & ~clr;
  end

endmodule

// File: tb/tb_lift_sched.sv
// Self-checking bench for lift_sched: expected output snapshots are queued as
// each cycle's stimulus is driven and compared once the DUT has clocked.
module tb_lift_sched;

  logic       in_clk;
  logic       in_rst;
  logic [3:0] in_call;
  logic [2:0] in_pos;
  logic       in_rdy;
  logic [1:0] o_tgt;
  logic [3:0] o_pend;
  logic       o_dir;
  logic       o_door;
  logic       o_busy;

  lift_sched #(.DOOR_CYC(4)) dut (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .in_call(in_call),
    .in_pos (in_pos),
    .in_rdy (in_rdy),
    .o_tgt  (o_tgt),
    .o_pend (o_pend),
    .o_dir  (o_dir),
    .o_door (o_door),
    .o_busy (o_busy)
  );

  typedef struct {
    string      tag;
    logic [8:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_open;
  int   ndoor;

  logic [8:0] obs;
  assign obs = {o_busy, o_door, o_dir, o_pend, o_tgt};

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] pk(input logic [1:0] tgt, input logic [3:0] pend,
                                    input logic dir, input logic door, input logic busy);
    return {busy, door, dir, pend, tgt};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pop_cmp();
    exp_t e;
    e = sb.pop_front();
    check(e.tag, {23'b0, obs}, {23'b0, e.val});
  endtask

  task automatic cyc(input logic [3:0] call, input logic [2:0] pos, input logic rdy,
                     input logic [1:0] tgt, input logic [3:0] pend, input logic dir,
                     input logic door, input logic busy, input string tag);
    in_call = call;
    in_pos  = pos;
    in_rdy  = rdy;
    sb.push_back('{tag, pk(tgt, pend, dir, door, busy)});
    @(posedge in_clk);
    #1;
    pop_cmp();
  endtask

  initial begin
`ifdef LIFT_SCHED_HOLD_EN
    ndoor = 6;
`else
    ndoor = 4;
`endif
    in_rst  = 1'b1;
    in_call = 4'b0000;
    in_pos  = 3'd1;
    in_rdy  = 1'b0;
    #1;
    sb.push_back('{"rst", pk(2'd0, 4'b0000, 1'b1, 1'b0, 1'b0)});
    pop_cmp();
    @(posedge in_clk);
    #1;
    in_rst = 1'b0;

    // Basic call, travel, door for four cycles, back to idle.
    cyc(4'b0100, 3'd1, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, 1'b1, "a_call");
    cyc(4'b0000, 3'd3, 1'b1, 2'd2, 4'b0000, 1'b1, 1'b1, 1'b1, "a_arr");
    repeat (3) cyc(4'b0000, 3'd3, 1'b0, 2'd2, 4'b0000, 1'b1, 1'b1, 1'b1, "a_door");
    cyc(4'b0000, 3'd3, 1'b0, 2'd2, 4'b0000, 1'b1, 1'b0, 1'b0, "a_idle");

    // Heading to floor 4, floor 2 call en route takes over the target.
    cyc(4'b1000, 3'd1, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0, 1'b1, "b_go");
    cyc(4'b0010, 3'd1, 1'b0, 2'd1, 4'b1010, 1'b1, 1'b0, 1'b1, "b_retgt");
    cyc(4'b0000, 3'd2, 1'b1, 2'd1, 4'b1000, 1'b1, 1'b1, 1'b1, "b_arr2");
    repeat (3) cyc(4'b0000, 3'd2, 1'b0, 2'd1, 4'b1000, 1'b1, 1'b1, 1'b1, "b_door2");
    cyc(4'b0000, 3'd2, 1'b0, 2'd3, 4'b1000, 1'b1, 1'b0, 1'b1, "b_resume");
    cyc(4'b0000, 3'd4, 1'b1, 2'd3, 4'b0000, 1'b1, 1'b1, 1'b1, "b_arr4");
    repeat (3) cyc(4'b0000, 3'd4, 1'b0, 2'd3, 4'b0000, 1'b1, 1'b1, 1'b1, "b_door4");
    cyc(4'b0000, 3'd4, 1'b0, 2'd3, 4'b0000, 1'b1, 1'b0, 1'b0, "b_idle");

    // Reversal at floor 4 and floor 1, then serve-ahead before turning back.
    cyc(4'b0001, 3'd4, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b0, 1'b1, "c_rev4");
    cyc(4'b0000, 3'd1, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b1, "c_arr1");
    repeat (3) cyc(4'b0000, 3'd1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b1, "c_door1");
    cyc(4'b0000, 3'd1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, "c_idle");
    cyc(4'b0100, 3'd1, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b0, 1'b1, "c_rev1");
    cyc(4'b0101, 3'd2, 1'b0, 2'd2, 4'b0101, 1'b1, 1'b0, 1'b1, "c_add");
    cyc(4'b0000, 3'd3, 1'b1, 2'd2, 4'b0001, 1'b1, 1'b1, 1'b1, "c_arr3");
    repeat (3) cyc(4'b0000, 3'd3, 1'b0, 2'd2, 4'b0001, 1'b1, 1'b1, 1'b1, "c_door3");
    cyc(4'b0000, 3'd3, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b0, 1'b1, "c_turn");
    cyc(4'b0000, 3'd2, 1'b1, 2'd0, 4'b0001, 1'b0, 1'b0, 1'b1, "c_rdy_nomatch");
    cyc(4'b0000, 3'd0, 1'b1, 2'd0, 4'b0001, 1'b0, 1'b0, 1'b1, "c_pos0");
    cyc(4'b0000, 3'd5, 1'b1, 2'd0, 4'b0001, 1'b0, 1'b0, 1'b1, "c_pos5");
    cyc(4'b0000, 3'd1, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b1, "c_arr1b");
    repeat (3) cyc(4'b0000, 3'd1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b1, "c_door1b");
    cyc(4'b0000, 3'd1, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, 1'b0, "c_idle2");

    // Call at current floor while idle: straight to DOOR; repeat call on door cycle 2.
    n_open = 0;
    cyc(4'b0010, 3'd2, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b1, "d_open");
    if (o_door) n_open++;
    cyc(4'b0000, 3'd2, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b1, "d_c2");
    if (o_door) n_open++;
    cyc(4'b0010, 3'd2, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b1, "d_recall");
    if (o_door) n_open++;
    for (int e = 4; e <= 8; e++) begin
      cyc(4'b0000, 3'd2, 1'b0, 2'd0, 4'b0000, 1'b0, (e <= ndoor), (e <= ndoor), "d_run");
      if (o_door) n_open++;
    end
    check("d_len", n_open, ndoor);

    // Asynchronous reset in the middle of a move.
    cyc(4'b1010, 3'd1, 1'b0, 2'd1, 4'b1010, 1'b1, 1'b0, 1'b1, "e_go");
    in_call = 4'b0000;
    in_rst  = 1'b1;
    #1;
    sb.push_back('{"e_rst_async", pk(2'd0, 4'b0000, 1'b1, 1'b0, 1'b0)});
    pop_cmp();
    @(posedge in_clk);
    #1;
    sb.push_back('{"e_rst_hold", pk(2'd0, 4'b0000, 1'b1, 1'b0, 1'b0)});
    pop_cmp();
    in_rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
